// File: rtl/video_pkg.sv
// Shared types and constants for the video bus arbiter.
// Optional feature macro: VIDEO_ARB_STARVE_GUARD_EN (host starvation guard).
package video_pkg;

   localparam int C_ADDR_W     = 14;
   localparam int C_STARVE_W   = 8;
   localparam int C_STARVE_LIM = 8;

   localparam logic [2:0] C_IDX_CTRL = 3'd0;
   localparam logic [2:0] C_IDX_STAT = 3'd2;
   localparam logic [2:0] C_IDX_ADDR = 3'd6;
   localparam logic [2:0] C_IDX_DATA = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REND,
      S_HRD,
      S_HWR
   } arb_state_t;

   function automatic logic [C_ADDR_W-1:0] f_vaddr_next(
      input logic [C_ADDR_W-1:0] vaddr,
      input logic                inc32
   );
      return vaddr + (inc32 ? C_ADDR_W'(32) : C_ADDR_W'(1));
   endfunction

endpackage

// File: rtl/video_host_regs.sv
// Host register port: two-write VRAM address latch, auto-increment,
// PPUDATA read buffer and the single-entry pending access.
module video_host_regs
   import video_pkg::*;
(
   input  logic                I_clock,
   input  logic                I_reset,
   input  logic [2:0]          I_host_addr,
   input  logic                I_host_strobe,
   input  logic                I_host_wren,
   input  logic [7:0]          I_host_data,
   input  logic                I_busy,
   input  logic                I_grant,
   input  logic                I_rd_done,
   input  logic [7:0]          I_rd_data,
   output logic [7:0]          O_host_data,
   output logic                O_pend,
   output logic                O_pend_wr,
   output logic [C_ADDR_W-1:0] O_pend_addr,
   output logic [7:0]          O_pend_data
);

   logic [C_ADDR_W-1:0] r_vaddr;
   logic                r_toggle;
   logic                r_inc32;
   logic [7:0]          r_rbuf;
   logic [7:0]          r_host_data;
   logic                r_pend;
   logic                r_pend_wr;
   logic [C_ADDR_W-1:0] r_pend_addr;
   logic [7:0]          r_pend_data;

   // Register decode, address latch, read buffer and pending-access queue
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         r_vaddr     <= '0;
         r_toggle    <= 1'b0;
         r_inc32     <= 1'b0;
         r_rbuf      <= 8'h00;
         r_host_data <= 8'h00;
         r_pend      <= 1'b0;
         r_pend_wr   <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= 8'h00;
      end else begin
         if (I_grant)
            r_pend <= 1'b0;
         if (I_rd_done)
            r_rbuf <= I_rd_data;
         if (I_host_strobe) begin
            case (I_host_addr)
               C_IDX_CTRL: begin
                  if (I_host_wren)
                     r_inc32 <= I_host_data[2];
                  else
                     r_host_data <= 8'h00;
               end
               C_IDX_STAT: begin
                  if (!I_host_wren) begin
                     r_toggle    <= 1'b0;
                     r_host_data <= 8'h00;
                  end
               end
               C_IDX_ADDR: begin
                  if (I_host_wren) begin
                     r_toggle <= ~r_toggle;
                     if (!r_toggle)
                        r_vaddr[13:8] <= I_host_data[5:0];
                     else
                        r_vaddr[7:0] <= I_host_data;
                  end else begin
                     r_host_data <= 8'h00;
                  end
               end
               C_IDX_DATA: begin
                  // a data access while one is outstanding is dropped whole
                  if (!I_busy) begin
                     r_pend      <= 1'b1;
                     r_pend_wr   <= I_host_wren;
                     r_pend_addr <= r_vaddr;
                     r_pend_data <= I_host_data;
                     r_vaddr     <= f_vaddr_next(r_vaddr, r_inc32);
                     if (!I_host_wren)
                        r_host_data <= r_rbuf;
                  end
               end
               default: begin
                  if (!I_host_wren)
                     r_host_data <= 8'h00;
               end
            endcase
         end
      end
   end

   assign O_host_data = r_host_data;
   assign O_pend      = r_pend;
   assign O_pend_wr   = r_pend_wr;
   assign O_pend_addr = r_pend_addr;
   assign O_pend_data = r_pend_data;

endmodule

// File: rtl/video_bus_arbiter.sv
// One-access-per-slot arbiter for the 14-bit video memory bus.
// Optional feature macro: VIDEO_ARB_STARVE_GUARD_EN (host starvation guard).
module video_bus_arbiter
   import video_pkg::*;
`ifdef VIDEO_ARB_STARVE_GUARD_EN
#(
   parameter int G_starve_lim = C_STARVE_LIM
)
`endif
(
   input  logic                I_clock,
   input  logic                I_reset,
   input  logic                I_slot,
   input  logic                I_rend_req,
   input  logic [C_ADDR_W-1:0] I_rend_addr,
   output logic                O_rend_valid,
   output logic [7:0]          O_rend_data,
   input  logic [2:0]          I_host_addr,
   input  logic                I_host_strobe,
   input  logic                I_host_wren,
   input  logic [7:0]          I_host_data,
   output logic [7:0]          O_host_data,
   output logic                O_host_busy,
   output logic [C_ADDR_W-1:0] O_cart_addr,
   output logic                O_cart_wren,
   input  logic [7:0]          I_cart_data,
   output logic [7:0]          O_cart_data
);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic                w_gnt_rend;
   logic                w_gnt_host;
   logic                w_force;
   logic                w_pend;
   logic                w_pend_wr;
   logic [C_ADDR_W-1:0] w_pend_addr;
   logic [7:0]          w_pend_data;
   logic                w_busy;
   logic [C_ADDR_W-1:0] r_cart_addr;
   logic                r_cart_wren;
   logic [7:0]          r_cart_data;
   logic                r_rend_valid;
   logic [7:0]          r_rend_data;

   assign w_busy = w_pend | (r_state == S_HRD) | (r_state == S_HWR);

   video_host_regs u_regs (
      .I_clock       (I_clock),
      .I_reset       (I_reset),
      .I_host_addr   (I_host_addr),
      .I_host_strobe (I_host_strobe),
      .I_host_wren   (I_host_wren),
      .I_host_data   (I_host_data),
      .I_busy        (w_busy),
      .I_grant       (w_gnt_host),
      .I_rd_done     (r_state == S_HRD),
      .I_rd_data     (I_cart_data),
      .O_host_data   (O_host_data),
      .O_pend        (w_pend),
      .O_pend_wr     (w_pend_wr),
      .O_pend_addr   (w_pend_addr),
      .O_pend_data   (w_pend_data)
   );

`ifdef VIDEO_ARB_STARVE_GUARD_EN
   logic [C_STARVE_W-1:0] r_starve;

   assign w_force = w_pend && (int'(r_starve) >= G_starve_lim);

   // Count slots a pending host access lost to render
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset)
         r_starve <= '0;
      else if (w_gnt_host)
         r_starve <= '0;
      else if (w_gnt_rend && w_pend && (r_starve != '1))
         r_starve <= r_starve + 1'b1;
   end
`else
   assign w_force = 1'b0;
`endif

   // State register
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Slot arbitration: render first unless host is being starved
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_rend  = 1'b0;
      w_gnt_host  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (I_slot) begin
               if (I_rend_req && !w_force) begin
                  w_gnt_rend  = 1'b1;
                  w_state_nxt = S_REND;
               end else if (w_pend) begin
                  w_gnt_host  = 1'b1;
                  w_state_nxt = w_pend_wr ? S_HWR : S_HRD;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus drive on grant, render data capture one cycle later
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         r_cart_addr  <= '0;
         r_cart_wren  <= 1'b0;
         r_cart_data  <= 8'h00;
         r_rend_valid <= 1'b0;
         r_rend_data  <= 8'h00;
      end else begin
         r_cart_wren  <= 1'b0;
         r_rend_valid <= 1'b0;
         if (w_gnt_rend)
            r_cart_addr <= I_rend_addr;
         if (w_gnt_host) begin
            r_cart_addr <= w_pend_addr;
            r_cart_wren <= w_pend_wr;
            if (w_pend_wr)
               r_cart_data <= w_pend_data;
         end
         if (r_state == S_REND) begin
            r_rend_valid <= 1'b1;
            r_rend_data  <= I_cart_data;
         end
      end
   end

   assign O_cart_addr  = r_cart_addr;
   assign O_cart_wren  = r_cart_wren;
   assign O_cart_data  = r_cart_data;
   assign O_rend_valid = r_rend_valid;
   assign O_rend_data  = r_rend_data;
   assign O_host_busy  = w_busy;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Directed bench for video_bus_arbiter.
// Covers VIDEO_ARB_STARVE_GUARD_EN both defined and undefined.
module tb_video_bus_arbiter;

   logic        I_clock = 1'b0;
   logic        I_reset = 1'b0;
   logic        I_slot = 1'b0;
   logic        I_rend_req = 1'b0;
   logic [13:0] I_rend_addr = '0;
   logic        O_rend_valid;
   logic [7:0]  O_rend_data;
   logic [2:0]  I_host_addr = '0;
   logic        I_host_strobe = 1'b0;
   logic        I_host_wren = 1'b0;
   logic [7:0]  I_host_data = '0;
   logic [7:0]  O_host_data;
   logic        O_host_busy;
   logic [13:0] O_cart_addr;
   logic        O_cart_wren;
   logic [7:0]  I_cart_data;
   logic [7:0]  O_cart_data;

   int n_chk = 0;
   int n_fail = 0;
   int n_wr = 0;
   int n_rv = 0;
   int w0;
   int v0;

   video_bus_arbiter dut (
      .I_clock       (I_clock),
      .I_reset       (I_reset),
      .I_slot        (I_slot),
      .I_rend_req    (I_rend_req),
      .I_rend_addr   (I_rend_addr),
      .O_rend_valid  (O_rend_valid),
      .O_rend_data   (O_rend_data),
      .I_host_addr   (I_host_addr),
      .I_host_strobe (I_host_strobe),
      .I_host_wren   (I_host_wren),
      .I_host_data   (I_host_data),
      .O_host_data   (O_host_data),
      .O_host_busy   (O_host_busy),
      .O_cart_addr   (O_cart_addr),
      .O_cart_wren   (O_cart_wren),
      .I_cart_data   (I_cart_data),
      .O_cart_data   (O_cart_data)
   );

   always #5 I_clock = ~I_clock;

   // memory model: byte = addr[7:0] ^ addr[13:8]
   assign I_cart_data = O_cart_addr[7:0] ^ {2'b00, O_cart_addr[13:8]};

   always @(posedge I_clock) begin
      if (O_cart_wren) n_wr++;
      if (O_rend_valid) n_rv++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_clock);
      #1;
   endtask

   task automatic host(input logic [2:0] a, input logic w,
                       input logic [7:0] d);
      I_host_addr   = a;
      I_host_wren   = w;
      I_host_data   = d;
      I_host_strobe = 1'b1;
      tick();
      I_host_strobe = 1'b0;
   endtask

   task automatic slot();
      I_slot = 1'b1;
      tick();
      I_slot = 1'b0;
   endtask

   initial begin
      tick();
      chk("rst_addr", 32'(O_cart_addr), 0);
      chk("rst_wren", 32'(O_cart_wren), 0);
      chk("rst_busy", 32'(O_host_busy), 0);
      chk("rst_hdata", 32'(O_host_data), 0);
      chk("rst_rvalid", 32'(O_rend_valid), 0);
      I_reset = 1'b1;
      tick();

      // write 0x5A at 0x2108
      host(3'd6, 1'b1, 8'h21);
      host(3'd6, 1'b1, 8'h08);
      host(3'd7, 1'b1, 8'h5A);
      chk("wr_busy_q", 32'(O_host_busy), 1);
      slot();
      chk("wr_addr", 32'(O_cart_addr), 32'h2108);
      chk("wr_wren", 32'(O_cart_wren), 1);
      chk("wr_data", 32'(O_cart_data), 32'h5A);
      chk("wr_busy_f", 32'(O_host_busy), 1);
      tick();
      chk("wr_wren_off", 32'(O_cart_wren), 0);
      chk("wr_busy_off", 32'(O_host_busy), 0);
      // read at incremented vaddr 0x2109
      host(3'd7, 1'b0, 8'h00);
      chk("rd0_old", 32'(O_host_data), 0);
      slot();
      chk("rd0_addr", 32'(O_cart_addr), 32'h2109);
      chk("rd0_wren", 32'(O_cart_wren), 0);
      tick();
      chk("rd0_busy", 32'(O_host_busy), 0);

      // inc32 and wrap from 0x3FF0
      host(3'd0, 1'b1, 8'h04);
      host(3'd2, 1'b0, 8'h00);
      host(3'd6, 1'b1, 8'h3F);
      host(3'd6, 1'b1, 8'hF0);
      host(3'd7, 1'b0, 8'h00);
      chk("rd1_old", 32'(O_host_data), 32'h28);
      slot();
      chk("rd1_addr", 32'(O_cart_addr), 32'h3FF0);
      tick();
      host(3'd7, 1'b0, 8'h00);
      chk("rd2_data", 32'(O_host_data), 32'hCF);
      slot();
      chk("rd2_wrap32", 32'(O_cart_addr), 32'h0010);
      tick();

      // +1 wrap from 0x3FFF
      host(3'd0, 1'b1, 8'h00);
      host(3'd6, 1'b1, 8'h3F);
      host(3'd6, 1'b1, 8'hFF);
      host(3'd7, 1'b1, 8'h11);
      slot();
      chk("w3_addr", 32'(O_cart_addr), 32'h3FFF);
      tick();
      host(3'd7, 1'b1, 8'h22);
      slot();
      chk("w4_wrap1", 32'(O_cart_addr), 32'h0000);
      chk("w4_data", 32'(O_cart_data), 32'h22);
      tick();

      // render beats pending host write on the same slot
      host(3'd6, 1'b1, 8'h05);
      host(3'd6, 1'b1, 8'h55);
      host(3'd7, 1'b1, 8'h77);
      I_rend_req  = 1'b1;
      I_rend_addr = 14'h1234;
      slot();
      chk("rn_addr", 32'(O_cart_addr), 32'h1234);
      chk("rn_wren", 32'(O_cart_wren), 0);
      chk("rn_busy", 32'(O_host_busy), 1);
      I_rend_req = 1'b0;
      tick();
      chk("rn_valid", 32'(O_rend_valid), 1);
      chk("rn_data", 32'(O_rend_data), 32'h26);
      tick();
      chk("rn_valid_off", 32'(O_rend_valid), 0);
      slot();
      chk("hw_addr", 32'(O_cart_addr), 32'h0555);
      chk("hw_wren", 32'(O_cart_wren), 1);
      chk("hw_data", 32'(O_cart_data), 32'h77);
      tick();

      // index 7 while busy is dropped
      host(3'd6, 1'b1, 8'h01);
      host(3'd6, 1'b1, 8'h00);
      w0 = n_wr;
      host(3'd7, 1'b1, 8'hAA);
      host(3'd7, 1'b1, 8'hBB);
      host(3'd7, 1'b0, 8'h00);
      chk("drop_hdata", 32'(O_host_data), 32'hCF);
      slot();
      chk("drop_addr", 32'(O_cart_addr), 32'h0100);
      chk("drop_data", 32'(O_cart_data), 32'hAA);
      tick();
      tick();
      slot();
      chk("idle_wren", 32'(O_cart_wren), 0);
      chk("idle_hold", 32'(O_cart_addr), 32'h0100);
      tick();
      chk("drop_count", 32'(n_wr - w0), 1);
      host(3'd7, 1'b1, 8'hCC);
      slot();
      chk("drop_vaddr", 32'(O_cart_addr), 32'h0101);
      tick();

      // starvation: render held, host read pending at 0x0200
      host(3'd6, 1'b1, 8'h02);
      host(3'd6, 1'b1, 8'h00);
      host(3'd7, 1'b0, 8'h00);
      chk("st_old", 32'(O_host_data), 32'h10);
      I_rend_req  = 1'b1;
      I_rend_addr = 14'h0300;
      for (int i = 0; i < 8; i++) begin
         slot();
         chk("st_rend", 32'(O_cart_addr), 32'h0300);
         tick();
      end
      v0 = n_rv;
      slot();
`ifdef VIDEO_ARB_STARVE_GUARD_EN
      chk("st_force", 32'(O_cart_addr), 32'h0200);
      tick();
      chk("st_novalid", 32'(O_rend_valid), 0);
      chk("st_busy", 32'(O_host_busy), 0);
      I_rend_req = 1'b0;
`else
      chk("st_starve", 32'(O_cart_addr), 32'h0300);
      tick();
      chk("st_valid", 32'(O_rend_valid), 1);
      chk("st_busy", 32'(O_host_busy), 1);
      I_rend_req = 1'b0;
      slot();
      chk("st_drain", 32'(O_cart_addr), 32'h0200);
      tick();
`endif
      tick();
      host(3'd7, 1'b0, 8'h00);
      chk("st_rbuf", 32'(O_host_data), 32'h02);
      slot();
      tick();

      // reset between grant and capture
      I_rend_req  = 1'b1;
      I_rend_addr = 14'h1111;
      v0 = n_rv;
      slot();
      chk("ra_addr", 32'(O_cart_addr), 32'h1111);
      I_rend_req = 1'b0;
      I_reset = 1'b0;
      #1;
      chk("ra_addr0", 32'(O_cart_addr), 0);
      chk("ra_hdata0", 32'(O_host_data), 0);
      chk("ra_busy0", 32'(O_host_busy), 0);
      chk("ra_valid0", 32'(O_rend_valid), 0);
      tick();
      tick();
      I_reset = 1'b1;
      tick();
      tick();
      chk("ra_nopulse", 32'(n_rv - v0), 0);
      chk("ra_rdata0", 32'(O_rend_data), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/video_bus_arbiter.md
# video_bus_arbiter

Sequences and shares the 14-bit video memory (cart) bus between the render fetch engine and the host register port. It owns the host-visible VRAM address latch (two-write), the PPUDATA read buffer and the auto-increment, and grants exactly one bus access per video dot slot. It sits between the video core and the cart/VRAM bus, replacing direct cart-bus drive from the video timing logic.

## Interface
- G_starve_lim, 8, consecutive render-won slots before a pending host access is forced (only with the guard macro).
- I_clock  in  1  system clock; all logic on its rising edge.
- I_reset  in  1  asynchronous, active-low reset.
- I_slot  in  1  one-cycle bus-slot pulse (driven by the video dot-rise strobe); pulses are ≥2 cycles apart.
- I_rend_req  in  1  render fetch request, sampled on I_slot.
- I_rend_addr  in  14  render fetch address.
- O_rend_valid  out  1  one-cycle pulse: O_rend_data holds fetched byte.
- O_rend_data  out  8  render fetch data.
- I_host_addr  in  3  host register index.
- I_host_strobe  in  1  one-cycle host access pulse.
- I_host_wren  in  1  1 = write, 0 = read, qualified by I_host_strobe.
- I_host_data  in  8  host write data.
- O_host_data  out  8  host read data (register index 7 only; 0 otherwise).
- O_host_busy  out  1  host access pending or in flight.
- O_cart_addr  out  14  bus address.
- O_cart_wren  out  1  bus write enable.
- I_cart_data  in  8  bus read data, valid one cycle after address.
- O_cart_data  out  8  bus write data.

## Operation
- Host registers decoded: index 0 write, bit 2 -> inc32 (increment 32 else 1); index 2 read -> clears write toggle; index 6 write -> toggle 0: vaddr[13:8] <= data[5:0], toggle 1: vaddr[7:0] <= data; toggle flips each index-6 write; index 7 -> data access. Others ignored.
- Index 7 read: O_host_data <= read buffer (old value) on the strobe edge; pending read queued at current vaddr; vaddr += inc at the strobe edge.
- Index 7 write: pending write queued with vaddr and data; vaddr += inc at strobe edge.
- Increment wraps modulo 2^14 (0x3FFF + 1 -> 0x0000; 0x3FF0 + 32 -> 0x0010).
- Queued access keeps its latched address; later index-6 writes do not alter it.
- Index-7 strobe while O_host_busy = 1: dropped entirely (no vaddr change, no buffer output change).
- States: S_IDLE, S_REND (render read issued), S_HRD (host read issued), S_HWR (host write issued). On I_slot in S_IDLE: render request wins; else pending host access; else stay. S_REND/S_HRD -> S_IDLE next cycle capturing I_cart_data; S_HWR -> S_IDLE next cycle.
- I_slot outside S_IDLE is ignored (cannot occur under the ≥2 spacing rule; must still not corrupt state).

## Timing
- Grant at slot edge t: O_cart_addr/O_cart_wren/O_cart_data registered at t. O_cart_wren high for exactly one cycle (t..t+1).
- Capture at edge t+1: render -> O_rend_data and O_rend_valid high for one cycle; host read -> read buffer updated, O_host_busy falls.
- Host write: O_host_busy falls at t+1.
- Host strobe coincident with I_slot: request is registered at that edge, eligible only from the next slot.
- O_cart_addr holds last value when idle; O_cart_wren 0 when idle.
- Reset values: all outputs 0; vaddr 0, toggle 0, inc32 0, buffer 0, state S_IDLE, starve count 0. Reset mid-access aborts it; no write is completed after reset release.

## Configuration
- VIDEO_ARB_STARVE_GUARD_EN defined: counter of slots where a host access was pending but render won; when it reaches G_starve_lim, the next slot grants host regardless of I_rend_req (render request unacked, no O_rend_valid); counter clears on any host grant.
- Not defined: render always wins; host may starve indefinitely; no counter logic.

## Structure
- video_pkg: state enum, register index constants (0, 2, 6, 7), address width 14, G_starve_lim default.
- One sub-module: video_host_regs (toggle, vaddr, inc32, read buffer, pending request); arbiter FSM stays in video_bus_arbiter.

## Test plan
- Writes idx6 0x21, 0x08 then idx7 0x5A -> one slot later O_cart_addr 0x2108, O_cart_wren pulse, O_cart_data 0x5A; vaddr 0x2109.
- idx0 0x04, vaddr 0x3FF0, idx7 read -> cart address 0x3FF0, vaddr becomes 0x0010; first read returns old buffer, second returns byte at 0x3FF0.
- I_rend_req with 0x1234 and pending host write on same slot -> render granted, O_rend_valid one cycle later with I_cart_data; host write on next slot.
- Index 7 strobe while busy -> dropped: vaddr unchanged, only one cart access.
- With VIDEO_ARB_STARVE_GUARD_EN, I_rend_req held high, host read pending -> host granted on 9th slot; without macro never granted.
- Assert I_reset between grant and capture -> all outputs 0 immediately, O_rend_valid never pulses.
